// File: rtl/dijkstra_scheduler.sv
// dijkstra_scheduler: arbitrates two requesters (HPS bridge = port 0,
// fabric reroute = port 1) round-robin onto one Dijkstra engine. It latches
// the winner's start/goal records, launches the engine under a watchdog,
// streams the resulting path back over valid/ready and ends with a one-cycle
// status response.
module dijkstra_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_PATH       = 100
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req,
  input  logic [271:0] req_start_node0,
  input  logic [271:0] req_start_node1,
  input  logic [271:0] req_goal_node0,
  input  logic [271:0] req_goal_node1,
  output logic [1:0]   grant,
  output logic         busy,
  output logic         eng_start,
  output logic         eng_abort,
  output logic [271:0] eng_start_node,
  output logic [271:0] eng_goal_node,
  input  logic         eng_done,
  input  logic         eng_success,
  input  logic [7:0]   eng_len,
  output logic [6:0]   eng_rd_addr,
  input  logic [31:0]  eng_rd_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_coord,
  output logic         out_last,
  output logic         out_owner,
  output logic         resp_valid,
  output logic         resp_owner,
  output logic         resp_success,
  output logic         resp_timeout,
  output logic [7:0]   resp_len
);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    STREAM,
    RESP
  } state_t;

  localparam logic [23:0] WD_LAST = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  MAX_LEN = 8'(MAX_PATH);

  state_t      state;
  logic        last_owner;
  logic        owner;
  logic        succ;
  logic        tmo;
  logic [7:0]  len;
  logic [6:0]  index;
  logic [23:0] wd;

  // Round-robin pick: a lone requester wins; on a tie the port that did not
  // win last time is served.
  logic       pick;
  logic [7:0] len_clamped;
  logic       is_last;

  assign pick        = (req == 2'b10) ? 1'b1 :
                       (req == 2'b11) ? ~last_owner : 1'b0;
  assign len_clamped = (eng_len > MAX_LEN) ? MAX_LEN : eng_len;
  assign is_last     = ({1'b0, index} == (len - 8'd1));

  // Stream and status outputs are thin views of registered state, so they
  // stay stable while the sink stalls.
  assign busy         = (state != IDLE);
  assign eng_rd_addr  = index;
  assign out_coord    = eng_rd_data;
  assign out_last     = out_valid & is_last;
  assign out_owner    = owner;
  assign resp_owner   = owner;
  assign resp_success = succ;
  assign resp_timeout = tmo;
  assign resp_len     = len;

  // Control FSM: arbitration, launch, watchdog, streaming and response.
  // NOTE: every register here uses <= so all updates in this block see the
  // pre-edge values; blocking assignments would make later lines read
  // half-updated state and break simulation/synthesis agreement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      last_owner     <= 1'b1;
      owner          <= 1'b0;
      succ           <= 1'b0;
      tmo            <= 1'b0;
      len            <= 8'd0;
      index          <= 7'd0;
      wd             <= 24'd0;
      grant          <= 2'b00;
      eng_start      <= 1'b0;
      eng_abort      <= 1'b0;
      eng_start_node <= '0;
      eng_goal_node  <= '0;
      out_valid      <= 1'b0;
      resp_valid     <= 1'b0;
    end else begin
      // Single-cycle pulses default low and are raised only on transitions.
      grant      <= 2'b00;
      eng_start  <= 1'b0;
      eng_abort  <= 1'b0;
      resp_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (|req) begin
            owner          <= pick;
            last_owner     <= pick;
            grant          <= pick ? 2'b10 : 2'b01;
            eng_start_node <= pick ? req_start_node1 : req_start_node0;
            eng_goal_node  <= pick ? req_goal_node1  : req_goal_node0;
            state          <= LAUNCH;
          end
        end

        LAUNCH: begin
          eng_start <= 1'b1;
          wd        <= 24'd0;
          state     <= WAIT;
        end

        WAIT: begin
          // A done arriving on the timeout cycle takes priority.
          if (eng_done) begin
            succ <= eng_success;
            len  <= len_clamped;
            if (eng_success && (len_clamped != 8'd0)) begin
              index     <= 7'd0;
              out_valid <= 1'b1;
              state     <= STREAM;
            end else begin
              resp_valid <= 1'b1;
              state      <= RESP;
            end
          end else if (wd == WD_LAST) begin
            eng_abort  <= 1'b1;
            succ       <= 1'b0;
            len        <= 8'd0;
            tmo        <= 1'b1;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            wd <= wd + 24'd1;
          end
        end

        STREAM: begin
          if (out_ready) begin
            if (is_last) begin
              out_valid  <= 1'b0;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              index <= index + 7'd1;
            end
          end
        end

        RESP: begin
          tmo   <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dijkstra_scheduler.sv
// tb_dijkstra_scheduler: directed bench for dijkstra_scheduler with a small
// path-memory engine model; timeout is shortened to 50 cycles.
module tb_dijkstra_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req;
  logic [271:0] req_start_node0, req_start_node1;
  logic [271:0] req_goal_node0, req_goal_node1;
  logic [1:0]   grant;
  logic         busy, eng_start, eng_abort;
  logic [271:0] eng_start_node, eng_goal_node;
  logic         eng_done, eng_success;
  logic [7:0]   eng_len;
  logic [6:0]   eng_rd_addr;
  logic [31:0]  eng_rd_data;
  logic         out_valid, out_ready, out_last, out_owner;
  logic [31:0]  out_coord;
  logic         resp_valid, resp_owner, resp_success, resp_timeout;
  logic [7:0]   resp_len;

  logic [31:0]  path_mem [128];

  int n_assert = 0;
  int n_fail   = 0;

  dijkstra_scheduler #(.TIMEOUT_CYCLES(50), .MAX_PATH(100)) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_start_node0(req_start_node0), .req_start_node1(req_start_node1),
    .req_goal_node0(req_goal_node0), .req_goal_node1(req_goal_node1),
    .grant(grant), .busy(busy), .eng_start(eng_start), .eng_abort(eng_abort),
    .eng_start_node(eng_start_node), .eng_goal_node(eng_goal_node),
    .eng_done(eng_done), .eng_success(eng_success), .eng_len(eng_len),
    .eng_rd_addr(eng_rd_addr), .eng_rd_data(eng_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_coord(out_coord),
    .out_last(out_last), .out_owner(out_owner),
    .resp_valid(resp_valid), .resp_owner(resp_owner), .resp_success(resp_success),
    .resp_timeout(resp_timeout), .resp_len(resp_len)
  );

  always #5 clk = ~clk;

  // Engine path array: combinational read.
  assign eng_rd_data = path_mem[eng_rd_addr];

  task automatic check(input string tag, input logic [271:0] obs, input logic [271:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All driving and sampling happens on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_grant(input logic [1:0] exp, input string tag);
    int k = 0;
    while (grant == 2'b00 && k < 20) begin
      tick();
      k++;
    end
    check(tag, grant, exp);
  endtask

  task automatic engine_done(input logic s, input logic [7:0] l);
    eng_done    = 1'b1;
    eng_success = s;
    eng_len     = l;
    tick();
    eng_done    = 1'b0;
    eng_success = 1'b0;
    eng_len     = 8'd0;
  endtask

  task automatic run_fail_txn(input logic [1:0] exp_grant, input logic exp_owner);
    wait_grant(exp_grant, "rr_grant");
    tick();
    check("rr_eng_start", eng_start, 1'b1);
    engine_done(1'b0, 8'd0);
    check("fail_no_valid", out_valid, 1'b0);
    check("fail_resp_valid", resp_valid, 1'b1);
    check("fail_resp_success", resp_success, 1'b0);
    check("fail_resp_len", resp_len, 8'd0);
    check("fail_resp_timeout", resp_timeout, 1'b0);
    check("fail_resp_owner", resp_owner, exp_owner);
    tick();
    check("fail_resp_pulse", resp_valid, 1'b0);
  endtask

  function automatic logic [31:0] clamp_coord(input int i);
    return {16'(i) + 16'h0100, 16'(i) ^ 16'h00aa};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, observed hang expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [31:0] t1_exp [3];
    logic [31:0] bp_exp [4];
    logic        ready_pat [8];
    int          beats;

    t1_exp    = '{32'h0010_0010, 32'h0050_0030, 32'h0082_0043};
    bp_exp    = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    reset           = 1'b0;
    req             = 2'b00;
    req_start_node0 = {224'h0, 16'h0013, 16'h0010, 16'h0010};
    req_goal_node0  = {224'h0, 16'h0045, 16'h0082, 16'h0043};
    req_start_node1 = {224'h0, 16'h0077, 16'h0021, 16'h0022};
    req_goal_node1  = {224'h0, 16'h0099, 16'h0031, 16'h0032};
    eng_done        = 1'b0;
    eng_success     = 1'b0;
    eng_len         = 8'd0;
    out_ready       = 1'b0;
    for (int i = 0; i < 128; i++) path_mem[i] = 32'h0;

    // Reset values
    tick();
    tick();
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_eng_start", eng_start, 1'b0);
    check("rst_eng_abort", eng_abort, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_len", resp_len, 8'd0);
    check("rst_start_node", eng_start_node, 272'h0);
    check("rst_rd_addr", eng_rd_addr, 7'd0);
    reset = 1'b1;
    tick();

    // Single request from port 0, three-beat path
    for (int i = 0; i < 3; i++) path_mem[i] = t1_exp[i];
    req = 2'b01;
    tick();
    check("t1_grant", grant, 2'b01);
    check("t1_busy", busy, 1'b1);
    check("t1_eng_start_early", eng_start, 1'b0);
    check("t1_start_node", eng_start_node, req_start_node0);
    check("t1_goal_node", eng_goal_node, req_goal_node0);
    req = 2'b00;
    tick();
    check("t1_grant_pulse", grant, 2'b00);
    check("t1_eng_start", eng_start, 1'b1);
    out_ready = 1'b1;
    engine_done(1'b1, 8'd3);
    for (int b = 0; b < 3; b++) begin
      check("t1_valid", out_valid, 1'b1);
      check("t1_coord", out_coord, t1_exp[b]);
      check("t1_last", out_last, b == 2);
      check("t1_owner", out_owner, 1'b0);
      tick();
    end
    check("t1_valid_end", out_valid, 1'b0);
    check("t1_resp_valid", resp_valid, 1'b1);
    check("t1_resp_success", resp_success, 1'b1);
    check("t1_resp_len", resp_len, 8'd3);
    check("t1_resp_owner", resp_owner, 1'b0);
    check("t1_resp_timeout", resp_timeout, 1'b0);
    tick();
    check("t1_resp_pulse", resp_valid, 1'b0);
    check("t1_idle", busy, 1'b0);
    out_ready = 1'b0;

    // Simultaneous held requests from reset: grants alternate 0,1,0; each
    // transaction also exercises the engine-failure path.
    reset = 1'b0;
    req   = 2'b11;
    tick();
    reset = 1'b1;
    run_fail_txn(2'b01, 1'b0);
    run_fail_txn(2'b10, 1'b1);
    run_fail_txn(2'b01, 1'b0);
    req = 2'b00;
    tick();

    // Backpressure on a four-beat stream from port 1
    for (int i = 0; i < 4; i++) path_mem[i] = bp_exp[i];
    req = 2'b10;
    wait_grant(2'b10, "bp_grant");
    check("bp_start_node", eng_start_node, req_start_node1);
    req = 2'b00;
    tick();
    check("bp_eng_start", eng_start, 1'b1);
    engine_done(1'b1, 8'd4);
    beats = 0;
    for (int k = 0; k < 8 && beats < 4; k++) begin
      check("bp_valid", out_valid, 1'b1);
      check("bp_coord", out_coord, bp_exp[beats]);
      check("bp_owner", out_owner, 1'b1);
      out_ready = ready_pat[k];
      if (ready_pat[k]) begin
        check("bp_last", out_last, beats == 3);
        beats++;
      end else begin
        check("bp_last_stall", out_last, 1'b0);
      end
      tick();
    end
    out_ready = 1'b0;
    check("bp_valid_end", out_valid, 1'b0);
    check("bp_resp_valid", resp_valid, 1'b1);
    check("bp_resp_len", resp_len, 8'd4);
    check("bp_resp_owner", resp_owner, 1'b1);
    tick();

    // Watchdog timeout: engine never completes
    req = 2'b01;
    wait_grant(2'b01, "to_grant");
    req = 2'b00;
    tick();
    check("to_eng_start", eng_start, 1'b1);
    repeat (49) tick();
    check("to_abort_early", eng_abort, 1'b0);
    check("to_resp_early", resp_valid, 1'b0);
    check("to_busy_wait", busy, 1'b1);
    tick();
    check("to_abort", eng_abort, 1'b1);
    check("to_resp_valid", resp_valid, 1'b1);
    check("to_resp_timeout", resp_timeout, 1'b1);
    check("to_resp_success", resp_success, 1'b0);
    check("to_resp_len", resp_len, 8'd0);
    tick();
    check("to_abort_pulse", eng_abort, 1'b0);
    check("to_idle", busy, 1'b0);

    // Length clamp: engine reports 120, exactly 100 beats stream out
    for (int i = 0; i < 128; i++) path_mem[i] = clamp_coord(i);
    req = 2'b01;
    wait_grant(2'b01, "cl_grant");
    req = 2'b00;
    tick();
    check("cl_eng_start", eng_start, 1'b1);
    out_ready = 1'b1;
    engine_done(1'b1, 8'd120);
    for (int b = 0; b < 100; b++) begin
      check("cl_valid", out_valid, 1'b1);
      check("cl_coord", out_coord, clamp_coord(b));
      check("cl_last", out_last, b == 99);
      tick();
    end
    check("cl_valid_end", out_valid, 1'b0);
    check("cl_resp_valid", resp_valid, 1'b1);
    check("cl_resp_len", resp_len, 8'd100);
    tick();

    // Asynchronous reset in the middle of a stream owned by port 0
    req = 2'b01;
    wait_grant(2'b01, "rs_grant");
    req = 2'b00;
    tick();
    engine_done(1'b1, 8'd10);
    repeat (5) tick();
    check("rs_streaming", out_valid, 1'b1);
    check("rs_rd_addr", eng_rd_addr, 7'd5);
    #2 reset = 1'b0;
    #1;
    check("rs_valid_drop", out_valid, 1'b0);
    check("rs_busy_drop", busy, 1'b0);
    check("rs_rd_addr_clr", eng_rd_addr, 7'd0);
    check("rs_node_clr", eng_start_node, 272'h0);
    out_ready = 1'b0;
    tick();
    reset = 1'b1;
    req   = 2'b11;
    tick();
    check("rs_tie_after_reset", grant, 2'b01);
    req = 2'b00;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
